// File: rtl/spu_mast_seq.sv
// spu_mast_seq: MA store sequencer streaming an MA-memory region to L2 as 8-byte stores.
// Optional watchdog timeout is compiled in when SPU_MAST_SEQ_WDOG_EN is defined.
//
// state | meaning
// IDLE  | waiting for start
// RD    | one-cycle MA memory read of the next word
// REQ   | store request held to the LSU until mast_ack
// DRAIN | fixed holdoff, then wait for all outstanding store acks
// DONE  | one-cycle completion pulse
module spu_mast_seq #(
  parameter int LEN_W  = 6,
  parameter int MEM_AW = 6,
  parameter int TMO_W  = 10
) (
  input  logic              rclk,
  input  logic              arst_l,
  input  logic              start,
  input  logic [LEN_W-1:0]  start_len,
  input  logic [36:0]       start_pa,
  input  logic [MEM_AW-1:0] start_memidx,
  input  logic              abort,
  input  logic              mast_ack,
  input  logic              allma_stacks_ok,
  output logic              streq,
  output logic [36:0]       st_pa,
  output logic              memrd_en,
  output logic [MEM_AW-1:0] memrd_idx,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              tmo_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_REQ,
    S_DRAIN,
    S_DONE
  } state_t;

  // Upstream ack counter lags mast_ack by two cycles, so DRAIN ignores it that long.
  localparam logic [1:0]       LP_HOLDOFF = 2'd2;
  localparam logic [LEN_W-1:0] LP_CNT_ONE = LEN_W'(1);

  state_t              r_state;
  logic [LEN_W-1:0]    r_cnt;
  logic [36:0]         r_pa;
  logic [MEM_AW-1:0]   r_idx;
  logic [1:0]          r_hold;
  logic                r_streq;
  logic                r_memrd_en;
  logic                r_busy;
  logic                r_done;
  logic                r_aborted;
  logic                w_tmo_hit;

`ifdef SPU_MAST_SEQ_WDOG_EN
  // Hit is flagged on the cycle the counter would reach all-ones.
  localparam logic [TMO_W-1:0] LP_WDOG_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  logic [TMO_W-1:0] r_wdog;
  logic             r_tmo_err;
  logic             w_wdog_run;

  assign w_wdog_run = ((r_state == S_REQ) && !mast_ack && !abort) ||
                      ((r_state == S_DRAIN) && (r_hold == 2'd0) && !allma_stacks_ok);
  assign w_tmo_hit  = w_wdog_run && (r_wdog == LP_WDOG_LAST);

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      r_wdog <= '0;
    end else if (w_wdog_run && !w_tmo_hit) begin
      r_wdog <= r_wdog + 1'b1;
    end else begin
      r_wdog <= '0;
    end
  end

  assign tmo_err = r_tmo_err;
`else
  assign w_tmo_hit = 1'b0;
  // Evaluates to 0 for every usable counter width.
  assign tmo_err   = (TMO_W < 1);
`endif

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_pa       <= '0;
      r_idx      <= '0;
      r_hold     <= '0;
      r_streq    <= 1'b0;
      r_memrd_en <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_aborted  <= 1'b0;
`ifdef SPU_MAST_SEQ_WDOG_EN
      r_tmo_err  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_aborted <= 1'b0;
`ifdef SPU_MAST_SEQ_WDOG_EN
            r_tmo_err <= 1'b0;
`endif
            r_busy    <= 1'b1;
            if (start_len != '0) begin
              r_cnt      <= start_len;
              r_pa       <= start_pa;
              r_idx      <= start_memidx;
              r_memrd_en <= 1'b1;
              r_state    <= S_RD;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end

        S_RD: begin
          r_memrd_en <= 1'b0;
          if (abort) begin
            r_aborted <= 1'b1;
            r_hold    <= LP_HOLDOFF;
            r_state   <= S_DRAIN;
          end else begin
            r_streq <= 1'b1;
            r_state <= S_REQ;
          end
        end

        S_REQ: begin
          if (mast_ack) begin
            // An ack coinciding with abort still counts as an accepted store.
            r_streq <= 1'b0;
            r_cnt   <= r_cnt - 1'b1;
            r_pa    <= r_pa + 1'b1;
            r_idx   <= r_idx + 1'b1;
            if (abort) begin
              r_aborted <= 1'b1;
              r_hold    <= LP_HOLDOFF;
              r_state   <= S_DRAIN;
            end else if (r_cnt > LP_CNT_ONE) begin
              r_memrd_en <= 1'b1;
              r_state    <= S_RD;
            end else begin
              r_hold  <= LP_HOLDOFF;
              r_state <= S_DRAIN;
            end
          end else if (abort) begin
            r_streq   <= 1'b0;
            r_aborted <= 1'b1;
            r_hold    <= LP_HOLDOFF;
            r_state   <= S_DRAIN;
          end else if (w_tmo_hit) begin
            r_streq   <= 1'b0;
`ifdef SPU_MAST_SEQ_WDOG_EN
            r_tmo_err <= 1'b1;
`endif
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end
        end

        S_DRAIN: begin
          if (r_hold != 2'd0) begin
            r_hold <= r_hold - 1'b1;
          end else if (allma_stacks_ok) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (w_tmo_hit) begin
`ifdef SPU_MAST_SEQ_WDOG_EN
            r_tmo_err <= 1'b1;
`endif
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_streq    <= 1'b0;
          r_memrd_en <= 1'b0;
          r_done     <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign streq     = r_streq;
  assign st_pa     = r_pa;
  assign memrd_en  = r_memrd_en;
  assign memrd_idx = r_idx;
  assign busy      = r_busy;
  assign done      = r_done;
  assign aborted   = r_aborted;

endmodule

// File: tb/tb_spu_mast_seq.sv
// Directed self-checking bench for spu_mast_seq; the watchdog scenario is
// included only when SPU_MAST_SEQ_WDOG_EN is defined (bench then uses TMO_W=4).
module tb_spu_mast_seq;

`ifdef SPU_MAST_SEQ_WDOG_EN
  localparam int TB_TMO_W = 4;
`else
  localparam int TB_TMO_W = 10;
`endif

  logic        rclk;
  logic        arst_l;
  logic        start;
  logic [5:0]  start_len;
  logic [36:0] start_pa;
  logic [5:0]  start_memidx;
  logic        abort;
  logic        mast_ack;
  logic        allma_stacks_ok;
  logic        streq;
  logic [36:0] st_pa;
  logic        memrd_en;
  logic [5:0]  memrd_idx;
  logic        busy;
  logic        done;
  logic        aborted;
  logic        tmo_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Results recorded by run_stream, checked by each scenario task.
  logic [36:0] acked_pa[$];
  logic [5:0]  rd_idx[$];
  int          n_ack, n_rise, first_rd, first_req, done_cyc, n_done, last_ack;
  logic        busy_after, aborted_after, tmo_after, tmo_at_done, streq_at_done;
  bit          timed_out;

  spu_mast_seq #(.LEN_W(6), .MEM_AW(6), .TMO_W(TB_TMO_W)) u_dut (
    .rclk            (rclk),
    .arst_l          (arst_l),
    .start           (start),
    .start_len       (start_len),
    .start_pa        (start_pa),
    .start_memidx    (start_memidx),
    .abort           (abort),
    .mast_ack        (mast_ack),
    .allma_stacks_ok (allma_stacks_ok),
    .streq           (streq),
    .st_pa           (st_pa),
    .memrd_en        (memrd_en),
    .memrd_idx       (memrd_idx),
    .busy            (busy),
    .done            (done),
    .aborted         (aborted),
    .tmo_err         (tmo_err)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  task automatic tick;
    @(posedge rclk);
    #1;
  endtask

  // Cycle 0 drives start; cycle c observes outputs then drives inputs for cycle c.
  // ack_age: ack on the Nth cycle streq is seen (0 = never ack).
  // allma_dly: allma rises this many cycles after the final ack (<0 = held high).
  task automatic run_stream(input int len, input logic [36:0] pa, input int idx,
                            input int abort_no, input int allma_dly, input int ack_age,
                            input int busy_start_cyc, input int max_cyc);
    int age;
    int total;
    acked_pa.delete();
    rd_idx.delete();
    n_ack = 0; n_rise = 0; first_rd = -1; first_req = -1;
    done_cyc = -1; n_done = 0; last_ack = -1;
    busy_after = 1'b0; aborted_after = 1'b0; tmo_after = 1'b0;
    tmo_at_done = 1'b0; streq_at_done = 1'b0;
    timed_out = 1'b1;
    age = 0;
    total = (abort_no != 0) ? abort_no : len;
    start = 1'b1;
    start_len = len[5:0];
    start_pa = pa;
    start_memidx = idx[5:0];
    mast_ack = 1'b0;
    abort = 1'b0;
    allma_stacks_ok = (allma_dly < 0);
    for (int c = 1; c <= max_cyc; c++) begin
      tick();
      start = (c == busy_start_cyc);
      if (start) begin
        start_len = 6'd7;
        start_pa = 37'h3ff;
        start_memidx = 6'd40;
      end
      if (memrd_en) begin
        rd_idx.push_back(memrd_idx);
        if (first_rd < 0) first_rd = c;
      end
      if (streq) begin
        if (age == 0) n_rise++;
        if (first_req < 0) first_req = c;
        age++;
      end else begin
        age = 0;
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = c;
          tmo_at_done = tmo_err;
          streq_at_done = streq;
        end
      end
      if (done_cyc >= 0 && c == done_cyc + 1) begin
        busy_after = busy;
        aborted_after = aborted;
        tmo_after = tmo_err;
        timed_out = 1'b0;
        break;
      end
      mast_ack = streq && (ack_age != 0) && (age == ack_age);
      abort = 1'b0;
      if (mast_ack) begin
        acked_pa.push_back(st_pa);
        n_ack++;
        last_ack = c;
        abort = (n_ack == abort_no);
      end
      if (allma_dly >= 0 && n_ack == total && last_ack >= 0 && c == last_ack + allma_dly)
        allma_stacks_ok = 1'b1;
    end
    start = 1'b0;
    mast_ack = 1'b0;
    abort = 1'b0;
    allma_stacks_ok = 1'b0;
  endtask

  task automatic test_reset;
    tick();
    tick();
    n_tests++;
    if ({streq, memrd_en, busy, done, aborted, tmo_err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got=%b want=000000", {streq, memrd_en, busy, done, aborted, tmo_err});
    end
    n_tests++;
    if (st_pa !== 37'h0 || memrd_idx !== 6'h0) begin
      n_fail++;
      $display("FAIL reset_addr st_pa=%h idx=%h want 0/0", st_pa, memrd_idx);
    end
    #2 arst_l = 1'b1;
    tick();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_busy got=%b want=0", busy);
    end
  endtask

  task automatic test_basic;
    logic [36:0] exp_pa [3] = '{37'h100, 37'h101, 37'h102};
    logic [5:0]  exp_idx [3] = '{6'd5, 6'd6, 6'd7};
    logic [36:0] got_pa;
    logic [5:0]  got_idx;
    run_stream(3, 37'h100, 5, 0, 2, 2, -1, 60);
    n_tests++;
    if (timed_out !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_timeout got=no done want=done");
    end
    n_tests++;
    if (n_ack != 3 || n_rise != 3) begin
      n_fail++;
      $display("FAIL basic_stores acks=%0d rises=%0d want 3/3", n_ack, n_rise);
    end
    for (int i = 0; i < 3; i++) begin
      got_pa = (i < acked_pa.size()) ? acked_pa[i] : 'x;
      got_idx = (i < rd_idx.size()) ? rd_idx[i] : 'x;
      n_tests++;
      if (got_pa !== exp_pa[i]) begin
        n_fail++;
        $display("FAIL basic_st_pa[%0d] got=%h want=%h", i, got_pa, exp_pa[i]);
      end
      n_tests++;
      if (got_idx !== exp_idx[i]) begin
        n_fail++;
        $display("FAIL basic_memrd_idx[%0d] got=%0d want=%0d", i, got_idx, exp_idx[i]);
      end
    end
    n_tests++;
    if (first_rd != 1 || first_req != 2) begin
      n_fail++;
      $display("FAIL basic_latency memrd_en@%0d streq@%0d want 1/2", first_rd, first_req);
    end
    n_tests++;
    if (done_cyc != 13 || n_done != 1) begin
      n_fail++;
      $display("FAIL basic_done cyc=%0d count=%0d want 13/1", done_cyc, n_done);
    end
    n_tests++;
    if (busy_after !== 1'b0 || aborted_after !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_after busy=%b aborted=%b want 0/0", busy_after, aborted_after);
    end
  endtask

  task automatic test_zero_len;
    run_stream(0, 37'h55, 3, 0, 2, 2, -1, 20);
    n_tests++;
    if (done_cyc != 1 || n_done != 1) begin
      n_fail++;
      $display("FAIL zero_done cyc=%0d count=%0d want 1/1", done_cyc, n_done);
    end
    n_tests++;
    if (first_req != -1 || first_rd != -1) begin
      n_fail++;
      $display("FAIL zero_no_activity streq@%0d memrd@%0d want none", first_req, first_rd);
    end
    n_tests++;
    if (busy_after !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_busy_after got=%b want=0", busy_after);
    end
  endtask

  task automatic test_abort;
    run_stream(4, 37'h40, 0, 2, 6, 2, -1, 60);
    n_tests++;
    if (n_ack != 2 || n_rise != 2 || rd_idx.size() != 2) begin
      n_fail++;
      $display("FAIL abort_stores acks=%0d rises=%0d reads=%0d want 2/2/2", n_ack, n_rise, rd_idx.size());
    end
    n_tests++;
    if (last_ack != 6 || done_cyc != 13 || n_done != 1) begin
      n_fail++;
      $display("FAIL abort_drain_wait ack@%0d done@%0d count=%0d want 6/13/1", last_ack, done_cyc, n_done);
    end
    n_tests++;
    if (aborted_after !== 1'b1 || busy_after !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_flag aborted=%b busy=%b want 1/0", aborted_after, busy_after);
    end
  endtask

  task automatic test_pa_wrap;
    logic [36:0] got0;
    logic [36:0] got1;
    run_stream(2, 37'h1FFFFFFFFF, 63, 0, -1, 2, -1, 40);
    got0 = (acked_pa.size() > 0) ? acked_pa[0] : 'x;
    got1 = (acked_pa.size() > 1) ? acked_pa[1] : 'x;
    n_tests++;
    if (got0 !== 37'h1FFFFFFFFF || got1 !== 37'h0) begin
      n_fail++;
      $display("FAIL wrap_st_pa got=%h,%h want 1fffffffff,0", got0, got1);
    end
    n_tests++;
    if (rd_idx.size() != 2 || rd_idx[rd_idx.size()-1] !== 6'd0) begin
      n_fail++;
      $display("FAIL wrap_memrd_idx reads=%0d want 2 ending at 0", rd_idx.size());
    end
    n_tests++;
    if (last_ack < 0 || done_cyc != last_ack + 4) begin
      n_fail++;
      $display("FAIL wrap_holdoff done@%0d ack@%0d want done=ack+4", done_cyc, last_ack);
    end
  endtask

  task automatic test_start_while_busy;
    logic [36:0] got0;
    logic [36:0] got1;
    run_stream(2, 37'h200, 10, 0, 2, 2, 3, 40);
    got0 = (acked_pa.size() > 0) ? acked_pa[0] : 'x;
    got1 = (acked_pa.size() > 1) ? acked_pa[1] : 'x;
    n_tests++;
    if (n_ack != 2 || got0 !== 37'h200 || got1 !== 37'h201) begin
      n_fail++;
      $display("FAIL busy_start_pa acks=%0d got=%h,%h want 2 of 200,201", n_ack, got0, got1);
    end
    n_tests++;
    if (rd_idx.size() != 2 || rd_idx[0] !== 6'd10 || rd_idx[rd_idx.size()-1] !== 6'd11) begin
      n_fail++;
      $display("FAIL busy_start_idx reads=%0d want 10,11", rd_idx.size());
    end
    n_tests++;
    if (aborted_after !== 1'b0 || n_done != 1) begin
      n_fail++;
      $display("FAIL busy_start_flags aborted=%b done_count=%0d want 0/1", aborted_after, n_done);
    end
  endtask

  task automatic test_reset_mid_req;
    bit seen;
    seen = 1'b0;
    start = 1'b1;
    start_len = 6'd3;
    start_pa = 37'h100;
    start_memidx = 6'd5;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      start = 1'b0;
      seen = streq;
    end
    n_tests++;
    if (!seen || st_pa !== 37'h100) begin
      n_fail++;
      $display("FAIL midreq_reach streq=%b st_pa=%h want 1/100", streq, st_pa);
    end
    arst_l = 1'b0;
    #1;
    n_tests++;
    if (streq !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL midreq_async streq=%b busy=%b done=%b want 0/0/0", streq, busy, done);
    end
    #1 arst_l = 1'b1;
    tick();
    n_tests++;
    if (busy !== 1'b0 || st_pa !== 37'h0 || memrd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL midreq_after busy=%b st_pa=%h memrd_en=%b want 0/0/0", busy, st_pa, memrd_en);
    end
  endtask

`ifdef SPU_MAST_SEQ_WDOG_EN
  task automatic test_wdog;
    run_stream(2, 37'h10, 0, 0, 2, 0, -1, 60);
    n_tests++;
    if (done_cyc != 17 || n_done != 1 || n_ack != 0) begin
      n_fail++;
      $display("FAIL wdog_done done@%0d count=%0d acks=%0d want 17/1/0", done_cyc, n_done, n_ack);
    end
    n_tests++;
    if (tmo_at_done !== 1'b1 || streq_at_done !== 1'b0 || tmo_after !== 1'b1) begin
      n_fail++;
      $display("FAIL wdog_flag tmo=%b streq=%b sticky=%b want 1/0/1", tmo_at_done, streq_at_done, tmo_after);
    end
    run_stream(1, 37'h20, 0, 0, 2, 2, -1, 40);
    n_tests++;
    if (tmo_after !== 1'b0 || n_ack != 1) begin
      n_fail++;
      $display("FAIL wdog_clear tmo=%b acks=%0d want 0/1", tmo_after, n_ack);
    end
  endtask
`endif

  initial begin
    arst_l = 1'b0;
    start = 1'b0;
    start_len = '0;
    start_pa = '0;
    start_memidx = '0;
    abort = 1'b0;
    mast_ack = 1'b0;
    allma_stacks_ok = 1'b0;
    test_reset();
    test_basic();
    test_zero_len();
    test_abort();
    test_pa_wrap();
    test_start_while_busy();
    test_reset_mid_req();
`ifdef SPU_MAST_SEQ_WDOG_EN
    test_wdog();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spu_mast_seq.md
Name: spu_mast_seq

Overview:
- MA store-sequencer in the SPU.
- Streams an MA-memory region out to L2 as back-to-back 8-byte stores, holding one store request to the LSU at a time and advancing on each store ack.
- Sits directly upstream of the SPU write-enable/ack-tracking stage:
  - drives the store request that stage qualifies;
  - consumes its store ack and its "all MA store acks returned" status to decide completion.

Parameters:
- LEN_W, 6, width of store word count (max 2^LEN_W-1 words).
- MEM_AW, 6, MA memory word index width.
- TMO_W, 10, watchdog counter width (used only with the optional feature).

Ports:
- rclk  in  1  clock.
- arst_l  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse launching an operation; sampled only in IDLE.
- start_len  in  LEN_W  number of 8-byte stores; 0 = no-op.
- start_pa  in  37  physical address bits [39:3] of the first store.
- start_memidx  in  MEM_AW  MA memory index of the first word.
- abort  in  1  kill request (uncorrectable error / thread kill).
- mast_ack  in  1  store accepted by LSU; valid only while streq=1.
- allma_stacks_ok  in  1  outstanding MA store-ack counter is zero.
- streq  out  1  store request to LSU/PCX packet mux.
- st_pa  out  37  PA[39:3] of the current store.
- memrd_en  out  1  MA memory read strobe.
- memrd_idx  out  MEM_AW  MA memory read index.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- aborted  out  1  sticky: last operation ended by abort; cleared on next accepted start.
- tmo_err  out  1  sticky watchdog error (tied 0 without the optional feature).

Behaviour:
- Reset (arst_l=0, async):
  - state=IDLE.
  - All outputs 0; st_pa=0; memrd_idx=0.
  - Internal remaining count = 0; drain holdoff = 0.
- States and transitions:
  - IDLE: on start with start_len!=0:
    - load cnt=start_len, pa=start_pa, idx=start_memidx;
    - clear aborted;
    - go RD.
  - IDLE: on start with start_len==0 go DONE.
  - RD (1 cycle):
    - memrd_en=1, memrd_idx=idx;
    - next state REQ (data is valid in REQ).
  - REQ:
    - streq=1, st_pa=pa; held stable until mast_ack.
    - On mast_ack: cnt-=1, pa+=1 (37-bit wrap at all-ones to 0), idx+=1 (mod 2^MEM_AW).
    - Then go RD if the pre-decrement cnt>1, else DRAIN.
    - streq deasserts the cycle after ack.
  - DRAIN:
    - Load a 2-cycle holdoff on entry; the ack counter upstream updates two cycles after ack.
    - After holdoff expires, go DONE when allma_stacks_ok=1.
  - DONE: done=1 for one cycle; go IDLE.
- Latency:
  - start at cycle N gives memrd_en at N+1 and streq at N+2.
  - Ack at cycle M gives the next memrd_en at M+1.
- abort handling:
  - In RD: go DRAIN; no request issued.
  - In REQ without ack: drop streq next cycle and go DRAIN.
  - In REQ with mast_ack in the same cycle: the store counts as accepted, then go DRAIN.
  - In any aborting case, set aborted=1.
  - In IDLE/DRAIN/DONE: no effect; DRAIN must still wait for outstanding acks.
- start while busy is ignored; registers are not disturbed.
- mast_ack outside REQ is ignored.

Optional Feature:
- Macro SPU_MAST_SEQ_WDOG_EN.
- When defined:
  - TMO_W-bit counter clears on state change and on mast_ack.
  - It increments each cycle in REQ or DRAIN (holdoff expired).
  - On reaching all-ones: set tmo_err=1 (sticky until next accepted start), drop streq, go DONE.
- When undefined: no counter; tmo_err constant 0; REQ/DRAIN wait indefinitely.

Test Plan:
- Reset mid-REQ (assert arst_l=0 with streq=1) -> streq, busy, done drop immediately without clock; after release state IDLE, st_pa=0.
- start_len=3, start_pa=0x100, start_memidx=5, ack 1 cycle after each streq, allma_stacks_ok rising 2 cycles after last ack:
  - three requests with st_pa=0x100,0x101,0x102;
  - memrd_idx=5,6,7;
  - done exactly once, busy low after.
- start_len=0 -> done at cycle N+1, no streq, no memrd_en.
- start_len=4, abort asserted same cycle as 2nd mast_ack:
  - exactly 2 stores issued;
  - waits in DRAIN while allma_stacks_ok=0;
  - done after it rises; aborted=1.
- start_pa=0x1FFFFFFFFF, start_len=2 -> second st_pa=0x0; allma_stacks_ok held 1 throughout -> done still waits the 2-cycle holdoff.
- With SPU_MAST_SEQ_WDOG_EN, TMO_W=4, no mast_ack -> after 15 REQ cycles tmo_err=1, streq=0, done pulses; next start clears tmo_err.
